pc_unit_ras: RTL

- Parametrised successor program counter for the multicycle CPU datapath.
- Holds the PC and keeps the address of the instruction currently executing (old_pc).
- Resolves unconditional and conditional writes, with branch-on-zero and branch-on-not-zero.
- Adds a trap entry path with EPC capture and a small return-address stack (RAS) for call/return.
- Sits between the next-PC mux and instruction memory; control comes from the main control FSM.

---
 rtl/pc_unit_ras.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pc_unit_ras.sv
// Program counter with trap entry, EPC capture and a circular return-address stack.
// Optional PC_ALIGN_CHECK_EN turns misaligned PC loads into traps and adds a misalign pulse.
module pc_unit_ras #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             alu_zero,
  input  logic             branch_ne,
  input  logic [WIDTH-1:0] next_pc,
  input  logic             call_push,
  input  logic             ret_pop,
  input  logic             trap,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] old_pc,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
`ifdef PC_ALIGN_CHECK_EN
  output logic             misalign,
`endif
  output logic             ras_unf
);

  localparam int unsigned AW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] old_q, old_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [AW-1:0]    sp_q, sp_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             take, empty, full, load;
  logic             wr_en;
  logic [AW-1:0]    wr_idx, top_idx;
  logic [WIDTH-1:0] tgt;

`ifdef PC_ALIGN_CHECK_EN
  logic mis_q, mis_d;
`endif

  assign take    = pc_write | (pc_write_cond & (alu_zero ^ branch_ne));
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign top_idx = sp_q - AW'(1);

  always_comb begin
    pc_d   = pc_q;
    old_d  = old_q;
    epc_d  = epc_q;
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wr_en  = 1'b0;
    wr_idx = sp_q;
    load   = 1'b0;
    tgt    = next_pc;
`ifdef PC_ALIGN_CHECK_EN
    mis_d  = 1'b0;
`endif
    if (trap) begin
      pc_d  = TRAP_PC;
      epc_d = pc_q;
    end else begin
      if (pc_write && !ret_pop) old_d = pc_q;
      if (ret_pop) begin
        load = 1'b1;
        if (!empty) begin
          tgt = ras_q[top_idx];
          // pop+push on one edge: swap the top slot in place, depth unchanged
          if (call_push && take) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
          end else begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          unf_d = 1'b1;
          if (call_push && take) begin
            wr_en = 1'b1;
            sp_d  = sp_q + AW'(1);
            cnt_d = cnt_q + CW'(1);
          end
        end
      end else if (take) begin
        load = 1'b1;
        if (call_push) begin
          // when full, sp already points at the oldest entry, so it is overwritten
          wr_en = 1'b1;
          sp_d  = sp_q + AW'(1);
          if (full) ovf_d = 1'b1;
          else      cnt_d = cnt_q + CW'(1);
        end
      end
      if (load) begin
        pc_d = tgt;
`ifdef PC_ALIGN_CHECK_EN
        if (tgt[1:0] != 2'b00) begin
          pc_d  = TRAP_PC;
          epc_d = tgt;
          mis_d = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RST_PC;
      old_q <= '0;
      epc_q <= '0;
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      mis_q <= 1'b0;
`endif
    end else begin
      pc_q  <= pc_d;
      old_q <= old_d;
      epc_q <= epc_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef PC_ALIGN_CHECK_EN
      mis_q <= mis_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_idx] <= pc_q;
  end

  assign pc_out    = pc_q;
  assign old_pc    = old_q;
  assign epc       = epc_q;
  assign ras_empty = empty;
  assign ras_full  = full;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;
`ifdef PC_ALIGN_CHECK_EN
  assign misalign  = mis_q;
`endif

endmodule
